// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic-light command scheduler:
// command codes, FSM states and configuration burst steps.
package traffic_lights_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_UNREG      = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_MAN,
    ST_GAP
  } state_e;

  // Burst order; the value doubles as the bit index
  // in the pending-step mask.
  typedef enum logic [2:0] {
    STEP_UNREG,
    STEP_RED,
    STEP_YELLOW,
    STEP_GREEN,
    STEP_FINAL
  } step_e;

endpackage

// File: rtl/tl_rr_arb2.sv
// Two-requester round-robin arbiter with registered pointer.
// req[0]/req[1] -> grant[0]/grant[1]; pointer moves on accept.
module tl_rr_arb2
  import traffic_lights_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr = 1 favours requester 1 on a tie
  logic ptr;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      req == 2'b11: grant = ptr ? 2'b10 : 2'b01;
      req == 2'b01: grant = 2'b01;
      req == 2'b10: grant = 2'b10;
      default:      grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/traffic_lights_cmd_sched.sv
// Shares the controller command port between a config requester
// (expanded into a burst) and a manual requester, with idle gaps.
// Ports: cfg_* / man_* valid-ready requests in; cmd_* pulses,
// busy_o and err_o out.
module traffic_lights_cmd_sched
  import traffic_lights_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [DATA_W-1:0] cfg_red_time_i,
  input  logic [DATA_W-1:0] cfg_yellow_time_i,
  input  logic [DATA_W-1:0] cfg_green_time_i,
  input  logic              cfg_enable_i,
  input  logic              man_valid_i,
  output logic              man_ready_o,
  input  logic [2:0]        man_type_i,
  input  logic [DATA_W-1:0] man_data_i,
  output logic [2:0]        cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = (GAP_CYCLES > 0) ?
    (($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state, state_n;
  logic [4:0]        rem, rem_n, avail;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] red, yel, grn;
  logic              en;
  logic [DATA_W-1:0] s_red, s_yel, s_grn;
  logic              s_en;
  logic [1:0]        req, grant;
  logic              idle, take_cfg, take_man, accept;
  logic              valid_n, err_n, emit, more;
  logic [2:0]        type_n;
  logic [DATA_W-1:0] data_n;
  step_e             pick;

  assign idle = (state == ST_IDLE);
  assign req  = {man_valid_i, cfg_valid_i};

  tl_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // Gated by reset so every output reads 0 while held in reset
  assign cfg_ready_o = rst_n_i & idle & grant[0];
  assign man_ready_o = rst_n_i & idle & grant[1];
  assign take_cfg    = cfg_valid_i & cfg_ready_o;
  assign take_man    = man_valid_i & man_ready_o;
  assign accept      = take_cfg | take_man;
  assign busy_o      = ~idle;

  // The first burst step is issued on the handshake edge,
  // before the payload registers hold the new values.
  assign s_red = take_cfg ? cfg_red_time_i    : red;
  assign s_yel = take_cfg ? cfg_yellow_time_i : yel;
  assign s_grn = take_cfg ? cfg_green_time_i  : grn;
  assign s_en  = take_cfg ? cfg_enable_i      : en;
  assign avail = take_cfg ?
    {1'b1, |cfg_green_time_i, |cfg_yellow_time_i,
     |cfg_red_time_i, 1'b1} : rem;
  assign more  = |avail;

  always_comb begin
    pick = STEP_FINAL;
    for (int i = 4; i >= 0; i--) begin
      if (avail[i]) pick = step_e'(i);
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    cnt_n   = cnt;
    valid_n = 1'b0;
    type_n  = '0;
    data_n  = '0;
    err_n   = 1'b0;
    emit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_cfg) begin
          emit = 1'b1;
        end else if (take_man && man_type_i >= 3'd6) begin
          err_n = 1'b1;
        end else if (take_man) begin
          state_n = ST_MAN;
          valid_n = 1'b1;
          type_n  = man_type_i;
          data_n  = (man_type_i >= 3'd3) ? man_data_i : '0;
        end
      end
      ST_SEQ, ST_MAN: begin
        if (GAP_CYCLES > 0) begin
          state_n = ST_GAP;
          cnt_n   = GAP_LOAD;
        end else if (more) begin
          emit = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (more) begin
          emit = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (emit) begin
      state_n = ST_SEQ;
      valid_n = 1'b1;
      rem_n   = avail & ~(5'b00001 << pick);
      unique case (pick)
        STEP_UNREG:  type_n = CMD_UNREG;
        STEP_RED: begin
          type_n = CMD_SET_RED;
          data_n = s_red;
        end
        STEP_YELLOW: begin
          type_n = CMD_SET_YELLOW;
          data_n = s_yel;
        end
        STEP_GREEN: begin
          type_n = CMD_SET_GREEN;
          data_n = s_grn;
        end
        default: type_n = s_en ? CMD_ON : CMD_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      rem         <= '0;
      cnt         <= '0;
      red         <= '0;
      yel         <= '0;
      grn         <= '0;
      en          <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      cnt         <= cnt_n;
      cmd_valid_o <= valid_n;
      cmd_type_o  <= type_n;
      cmd_data_o  <= data_n;
      err_o       <= err_n;
      if (take_cfg) begin
        red <= cfg_red_time_i;
        yel <= cfg_yellow_time_i;
        grn <= cfg_green_time_i;
        en  <= cfg_enable_i;
      end
    end
  end

endmodule

// File: tb/tb_traffic_lights_cmd_sched.sv
// Bench for traffic_lights_cmd_sched: cycle model of the
// scheduling rules plus directed literal checks (G=2 and G=0).
module tb_traffic_lights_cmd_sched;

  localparam int G  = 2;
  localparam int NC = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_en;
  logic [15:0] cfg_red, cfg_yel, cfg_grn;
  logic        man_valid;
  logic [2:0]  man_type;
  logic [15:0] man_data;
  logic        cfg_ready, man_ready;
  logic [2:0]  cmd_type;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        busy, err;

  logic        cfg_valid0, cfg_en0;
  logic [15:0] cfg_red0, cfg_yel0, cfg_grn0;
  logic        man_valid0;
  logic [2:0]  man_type0;
  logic [15:0] man_data0;
  logic        cfg_ready0, man_ready0;
  logic [2:0]  cmd_type0;
  logic        cmd_valid0;
  logic [15:0] cmd_data0;
  logic        busy0, err0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  traffic_lights_cmd_sched #(.GAP_CYCLES(G), .DATA_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_red_time_i(cfg_red), .cfg_yellow_time_i(cfg_yel),
    .cfg_green_time_i(cfg_grn), .cfg_enable_i(cfg_en),
    .man_valid_i(man_valid), .man_ready_o(man_ready),
    .man_type_i(man_type), .man_data_i(man_data),
    .cmd_type_o(cmd_type), .cmd_valid_o(cmd_valid),
    .cmd_data_o(cmd_data), .busy_o(busy), .err_o(err)
  );

  traffic_lights_cmd_sched #(.GAP_CYCLES(0), .DATA_W(16)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_valid_i(cfg_valid0), .cfg_ready_o(cfg_ready0),
    .cfg_red_time_i(cfg_red0), .cfg_yellow_time_i(cfg_yel0),
    .cfg_green_time_i(cfg_grn0), .cfg_enable_i(cfg_en0),
    .man_valid_i(man_valid0), .man_ready_o(man_ready0),
    .man_type_i(man_type0), .man_data_i(man_data0),
    .cmd_type_o(cmd_type0), .cmd_valid_o(cmd_valid0),
    .cmd_data_o(cmd_data0), .busy_o(busy0), .err_o(err0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d",
               nm, cyc, act, exp);
    end
  endtask

  // Model: expected pulses/errors per cycle, busy window, rr pointer
  bit          pv [NC];
  logic [2:0]  pt [NC];
  logic [15:0] pd [NC];
  bit          pe [NC];
  int          free_at = 0;
  bit          ptr = 0;
  bit          m_cr, m_mr;

  always @(negedge clk) begin
    bit idle, gc, gm;
    int n, c;
    int ty [5];
    int da [5];
    m_cr = 0;
    m_mr = 0;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        pv[i] = 0; pt[i] = 0; pd[i] = 0; pe[i] = 0;
      end
      free_at = 0;
      ptr = 0;
    end else begin
      idle = cyc >= free_at;
      gc = cfg_valid && (!man_valid || !ptr);
      gm = man_valid && (!cfg_valid || ptr);
      m_cr = idle && gc;
      m_mr = idle && gm;
    end
    chk("m_cmd_valid", 32'(cmd_valid), 32'(pv[cyc]));
    chk("m_cmd_type", 32'(cmd_type), 32'(pt[cyc]));
    chk("m_cmd_data", 32'(cmd_data), 32'(pd[cyc]));
    chk("m_err", 32'(err), 32'(pe[cyc]));
    chk("m_busy", 32'(busy), 32'(rst_n && cyc < free_at));
    chk("m_cfg_ready", 32'(cfg_ready), 32'(m_cr));
    chk("m_man_ready", 32'(man_ready), 32'(m_mr));
    if (m_cr) begin
      n = 0;
      ty[n] = 2; da[n] = 0; n++;
      if (cfg_red != 0) begin ty[n] = 4; da[n] = int'(cfg_red); n++; end
      if (cfg_yel != 0) begin ty[n] = 5; da[n] = int'(cfg_yel); n++; end
      if (cfg_grn != 0) begin ty[n] = 3; da[n] = int'(cfg_grn); n++; end
      ty[n] = cfg_en ? 0 : 1; da[n] = 0; n++;
      for (int j = 0; j < n; j++) begin
        c = cyc + 1 + j * (G + 1);
        if (c < NC) begin
          pv[c] = 1; pt[c] = 3'(ty[j]); pd[c] = 16'(da[j]);
        end
      end
      free_at = cyc + 1 + n * (G + 1);
      ptr = 1;
    end else if (m_mr) begin
      c = cyc + 1;
      if (man_type >= 3'd6) begin
        if (c < NC) pe[c] = 1;
        free_at = c;
      end else begin
        if (c < NC) begin
          pv[c] = 1; pt[c] = man_type;
          pd[c] = (man_type >= 3'd3) ? man_data : 16'd0;
        end
        free_at = c + 1 + G;
      end
      ptr = 0;
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_at(input string nm, input int c, input bit v,
                          input int t, input int d);
    goto(c);
    #1;
    chk({nm, "_v"}, 32'(cmd_valid), 32'(v));
    chk({nm, "_t"}, 32'(cmd_type), 32'(t));
    chk({nm, "_d"}, 32'(cmd_data), 32'(d));
  endtask

  task automatic pulse0_at(input string nm, input int c, input bit v,
                           input int t, input int d);
    goto(c);
    #1;
    chk({nm, "_v"}, 32'(cmd_valid0), 32'(v));
    chk({nm, "_t"}, 32'(cmd_type0), 32'(t));
    chk({nm, "_d"}, 32'(cmd_data0), 32'(d));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t1, t2, m, c, z;
    rst_n = 0;
    cfg_valid = 1; cfg_red = 100; cfg_yel = 200; cfg_grn = 300;
    cfg_en = 1;
    man_valid = 1; man_type = 5; man_data = 42;
    cfg_valid0 = 0; cfg_red0 = 0; cfg_yel0 = 0; cfg_grn0 = 0;
    cfg_en0 = 0; man_valid0 = 0; man_type0 = 0; man_data0 = 0;

    goto(2);
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_man_ready", 32'(man_ready), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    r = 3;
    goto(r);
    rst_n = 1;
    #1;
    chk("rr0_cfg_ready", 32'(cfg_ready), 1);
    chk("rr0_man_ready", 32'(man_ready), 0);
    pulse_at("rr0_p0", r + 1, 1, 2, 0);
    pulse_at("rr0_p1", r + 4, 1, 4, 100);
    goto(r + 16);
    #1;
    chk("rr1_man_ready", 32'(man_ready), 1);
    chk("rr1_cfg_ready", 32'(cfg_ready), 0);
    pulse_at("rr1_p", r + 17, 1, 5, 42);
    goto(r + 20);
    #1;
    chk("rr2_cfg_ready", 32'(cfg_ready), 1);
    chk("rr2_man_ready", 32'(man_ready), 0);
    goto(r + 21);
    cfg_valid = 0; man_valid = 0;

    t1 = r + 36;
    goto(t1);
    cfg_valid = 1; cfg_red = 10000; cfg_yel = 3000; cfg_grn = 8000;
    cfg_en = 1;
    #1;
    chk("t1_ready", 32'(cfg_ready), 1);
    goto(t1 + 1);
    cfg_valid = 0; cfg_red = 1; cfg_yel = 1; cfg_grn = 1; cfg_en = 0;
    pulse_at("t1_p0", t1 + 1, 1, 2, 0);
    pulse_at("t1_g1", t1 + 2, 0, 0, 0);
    pulse_at("t1_p1", t1 + 4, 1, 4, 10000);
    pulse_at("t1_p2", t1 + 7, 1, 5, 3000);
    pulse_at("t1_p3", t1 + 10, 1, 3, 8000);
    pulse_at("t1_p4", t1 + 13, 1, 0, 0);
    pulse_at("t1_end", t1 + 14, 0, 0, 0);
    goto(t1 + 15);
    cfg_valid = 1; cfg_red = 777; cfg_yel = 0; cfg_grn = 0; cfg_en = 0;
    #1;
    chk("t1_busy_ready", 32'(cfg_ready), 0);
    t2 = t1 + 16;
    goto(t2);
    #1;
    chk("t1_ready_again", 32'(cfg_ready), 1);
    goto(t2 + 1);
    cfg_valid = 0;
    pulse_at("t2_p0", t2 + 1, 1, 2, 0);
    pulse_at("t2_p1", t2 + 4, 1, 4, 777);
    pulse_at("t2_p2", t2 + 7, 1, 1, 0);
    goto(t2 + 9);
    #1;
    chk("t2_busy", 32'(busy), 1);
    goto(t2 + 10);
    #1;
    chk("t2_idle", 32'(busy), 0);

    m = t2 + 10;
    goto(m);
    man_valid = 1; man_type = 7; man_data = 55;
    #1;
    chk("m7_ready", 32'(man_ready), 1);
    goto(m + 1);
    man_type = 3; man_data = 500;
    #1;
    chk("m7_err", 32'(err), 1);
    chk("m7_valid", 32'(cmd_valid), 0);
    chk("m7_ready_again", 32'(man_ready), 1);
    goto(m + 2);
    man_valid = 0;
    #1;
    chk("m7_err_once", 32'(err), 0);
    pulse_at("m3_p", m + 2, 1, 3, 500);
    goto(m + 4);
    man_valid = 1; man_type = 0; man_data = 999;
    #1;
    chk("m3_busy_ready", 32'(man_ready), 0);
    goto(m + 5);
    #1;
    chk("m3_ready_again", 32'(man_ready), 1);
    goto(m + 6);
    man_valid = 0;
    pulse_at("m0_p", m + 6, 1, 0, 0);

    c = m + 9;
    goto(c);
    cfg_valid = 1; cfg_red = 5; cfg_yel = 6; cfg_grn = 7; cfg_en = 0;
    pulse_at("rs_p1", c + 4, 1, 4, 5);
    goto(c + 5);
    #1;
    chk("rs_busy_pre", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_valid", 32'(cmd_valid), 0);
    chk("rs_ready", 32'(cfg_ready), 0);
    goto(c + 7);
    rst_n = 1;
    #1;
    chk("rs_ready_after", 32'(cfg_ready), 1);
    chk("rs_no_resume", 32'(cmd_valid), 0);
    goto(c + 8);
    cfg_valid = 0;
    pulse_at("rs_new_p0", c + 8, 1, 2, 0);

    z = c + 23;
    goto(z);
    cfg_valid0 = 1; cfg_red0 = 1; cfg_yel0 = 2; cfg_grn0 = 3;
    cfg_en0 = 1;
    goto(z + 1);
    cfg_valid0 = 0;
    pulse0_at("g0_p0", z + 1, 1, 2, 0);
    pulse0_at("g0_p1", z + 2, 1, 4, 1);
    pulse0_at("g0_p2", z + 3, 1, 5, 2);
    pulse0_at("g0_p3", z + 4, 1, 3, 3);
    goto(z + 5);
    cfg_valid0 = 1; cfg_red0 = 0; cfg_yel0 = 0; cfg_grn0 = 0;
    cfg_en0 = 0;
    pulse0_at("g0_p4", z + 5, 1, 0, 0);
    chk("g0_busy_ready", 32'(cfg_ready0), 0);
    chk("g0_busy", 32'(busy0), 1);
    goto(z + 6);
    #1;
    chk("g0_idle", 32'(busy0), 0);
    chk("g0_idle_valid", 32'(cmd_valid0), 0);
    chk("g0_ready", 32'(cfg_ready0), 1);
    goto(z + 7);
    cfg_valid0 = 0;
    pulse0_at("g0_q0", z + 7, 1, 2, 0);
    pulse0_at("g0_q1", z + 8, 1, 1, 0);
    goto(z + 9);
    #1;
    chk("g0_q_idle", 32'(busy0), 0);

    goto(z + 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
